// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer in front of the FFT core: absorbs a stalling sample stream and
// replays each complete frame as an unbroken burst with a start pulse and its captured mode.
module fft_frame_feeder #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FRAME_LEN  = 64,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_sof,
  input  logic              s_mode,
  output logic              s_ready,
  output logic [DATA_W-1:0] fft_data,
  output logic              fft_start,
  output logic              fft_valid,
  output logic              fft_mode,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned PtrW = $clog2(FRAME_LEN);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FRAME_LEN - 1);
  localparam logic [GapW-1:0] LastGap = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBurst, StGap} state_e;

  state_e            state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic [1:0]        bank_mode_q, bank_mode_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic              discard_q, discard_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [DATA_W-1:0] fft_data_q, fft_data_d;
  logic              fft_start_q, fft_start_d;
  logic              fft_valid_q, fft_valid_d;
  logic              fft_mode_q, fft_mode_d;

  logic [DATA_W-1:0] mem_q [2*FRAME_LEN];
  logic              mem_we;
  logic [PtrW:0]     mem_waddr;
  logic              accept;
  logic              drop_inc;

  assign s_ready = rst & ~full_q[wr_bank_q];
  assign accept  = s_valid & s_ready;

  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    bank_mode_d = bank_mode_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    gap_cnt_d   = gap_cnt_q;
    discard_d   = discard_q;
    drop_cnt_d  = drop_cnt_q;
    fft_data_d  = '0;
    fft_start_d = 1'b0;
    fft_valid_d = 1'b0;
    fft_mode_d  = fft_mode_q;
    mem_we      = 1'b0;
    mem_waddr   = {wr_bank_q, wr_ptr_q};
    drop_inc    = 1'b0;

    // Write side: sof always restarts a frame; stray beats before a sof are counted once.
    if (accept) begin
      if (s_sof) begin
        mem_we                 = 1'b1;
        mem_waddr              = {wr_bank_q, {PtrW{1'b0}}};
        bank_mode_d[wr_bank_q] = s_mode;
        wr_ptr_d               = PtrW'(1);
        discard_d              = 1'b0;
        drop_inc               = (wr_ptr_q != '0);
      end else if (wr_ptr_q == '0) begin
        drop_inc  = ~discard_q;
        discard_d = 1'b1;
      end else begin
        mem_we = 1'b1;
        if (wr_ptr_q == LastPtr) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
          wr_ptr_d          = '0;
        end else begin
          wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
      end
    end

    if (drop_inc && (drop_cnt_q != 8'hff)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (full_q[rd_bank_q]) begin
          state_d  = StBurst;
          rd_ptr_d = '0;
        end
      end
      StBurst: begin
        fft_valid_d = 1'b1;
        fft_data_d  = mem_q[{rd_bank_q, rd_ptr_q}];
        fft_start_d = (rd_ptr_q == '0);
        if (rd_ptr_q == '0) begin
          fft_mode_d = bank_mode_q[rd_bank_q];
        end
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (rd_ptr_q == LastPtr) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          rd_ptr_d          = '0;
          gap_cnt_d         = '0;
          state_d           = (GAP_CYCLES == 0) ? StIdle : StGap;
        end
      end
      StGap: begin
        if (gap_cnt_q == LastGap) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      full_q      <= '0;
      bank_mode_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      gap_cnt_q   <= '0;
      discard_q   <= 1'b0;
      drop_cnt_q  <= '0;
      fft_data_q  <= '0;
      fft_start_q <= 1'b0;
      fft_valid_q <= 1'b0;
      fft_mode_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      bank_mode_q <= bank_mode_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      gap_cnt_q   <= gap_cnt_d;
      discard_q   <= discard_d;
      drop_cnt_q  <= drop_cnt_d;
      fft_data_q  <= fft_data_d;
      fft_start_q <= fft_start_d;
      fft_valid_q <= fft_valid_d;
      fft_mode_q  <= fft_mode_d;
    end
  end

  // Sample storage carries no reset; validity is tracked by the full flags alone.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= s_data;
    end
  end

  assign fft_data  = fft_data_q;
  assign fft_start = fft_start_q;
  assign fft_valid = fft_valid_q;
  assign fft_mode  = fft_mode_q;
  assign drop_cnt  = drop_cnt_q;
  assign busy      = (state_q != StIdle) | full_q[0] | full_q[1];

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder: frame-level queue model of accepted beats versus the replayed
// bursts, with vector table scenarios plus backpressure, reset and random-gap sequences.
module tb_fft_frame_feeder;

  localparam int unsigned DW = 32;
  localparam int unsigned FL = 64;
  localparam int unsigned G  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid, s_sof, s_mode, s_ready;
  logic [DW-1:0] fft_data;
  logic          fft_start, fft_valid, fft_mode, busy;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  fft_frame_feeder #(
    .DATA_W    (DW),
    .FRAME_LEN (FL),
    .GAP_CYCLES(G)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_sof    (s_sof),
    .s_mode   (s_mode),
    .s_ready  (s_ready),
    .fft_data (fft_data),
    .fft_start(fft_start),
    .fft_valid(fft_valid),
    .fft_mode (fft_mode),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: frames as seen at the input, replayed in arrival order
  logic [DW-1:0] part_beats[$];
  bit            part_mode;
  bit            discarding;
  int            exp_drop;
  logic [DW-1:0] exp_data[$];
  bit            exp_mode[$];
  int            n_acc;
  int            stall_at;
  int            last_acc_cyc;

  // Output tracking
  bit in_burst;
  int idx;
  bit cur_mode;
  bit last_mode;
  int frames_out;
  int start_t[$];

  typedef struct {
    int            junk;
    int            partial;
    bit            mode;
    logic [DW-1:0] base;
    int            exp_drop;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    if (fft_valid) begin
      if (fft_start) begin
        if (in_burst) check("burst_cut_short", idx, FL);
        check("frame_pending", exp_mode.size() > 0, 1);
        in_burst = 1;
        idx = 0;
        start_t.push_back(cyc);
        cur_mode = (exp_mode.size() > 0) ? exp_mode.pop_front() : 1'b0;
      end else begin
        check("valid_without_start", in_burst, 1);
      end
      if (in_burst) begin
        check("data_available", exp_data.size() > 0, 1);
        if (exp_data.size() > 0) check("fft_data", fft_data, exp_data.pop_front());
        check("fft_mode", fft_mode, cur_mode);
        idx++;
        if (idx == FL) begin
          in_burst = 0;
          frames_out++;
          last_mode = cur_mode;
        end
      end
    end else begin
      check("burst_contiguous", in_burst, 0);
      in_burst = 0;
      check("idle_start", fft_start, 0);
      check("idle_data", fft_data, 0);
      check("mode_hold", fft_mode, last_mode);
    end
    check("drop_cnt", drop_cnt, exp_drop);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic bump_drop();
    if (exp_drop < 255) exp_drop++;
  endtask

  task automatic model_beat(input logic [DW-1:0] d, input bit sof, input bit m);
    n_acc++;
    if (sof) begin
      if (part_beats.size() > 0) bump_drop();
      part_beats.delete();
      part_beats.push_back(d);
      part_mode  = m;
      discarding = 0;
    end else if (part_beats.size() == 0) begin
      if (!discarding) bump_drop();
      discarding = 1;
    end else begin
      part_beats.push_back(d);
      if (part_beats.size() == FL) begin
        foreach (part_beats[i]) exp_data.push_back(part_beats[i]);
        exp_mode.push_back(part_mode);
        part_beats.delete();
      end
    end
  endtask

  task automatic beat(input logic [DW-1:0] d, input bit sof, input bit m);
    bit acc = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    // mode outside the sof beat must be ignored, so scramble it
    s_mode  = sof ? m : 1'($urandom_range(1));
    for (int t = 0; t < 500 && !acc; t++) begin
      acc = s_ready;
      if (acc) model_beat(d, sof, m);
      else if (stall_at < 0) stall_at = n_acc;
      tick();
      if (acc) last_acc_cyc = cyc;
    end
    check("s_ready_timeout", acc, 1);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input bit m, input bit rnd);
    for (int k = 0; k < FL; k++) begin
      if (rnd) begin
        while ($urandom_range(1) == 0) idle(1);
        beat($urandom, k == 0, m);
      end else begin
        beat(base + DW'(k), k == 0, m);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    s_valid = 1'b0;
    s_sof = 1'b0;
    s_mode = 1'b0;
    s_data = '0;
    part_beats.delete();
    exp_data.delete();
    exp_mode.delete();
    discarding = 0;
    exp_drop = 0;
    in_burst = 0;
    idx = 0;
    last_mode = 0;
    frames_out = 0;
    start_t.delete();
    n_acc = 0;
    stall_at = -1;
    tick();
    check("rst_fft_valid", fft_valid, 0);
    check("rst_fft_start", fft_start, 0);
    check("rst_fft_data", fft_data, 0);
    check("rst_fft_mode", fft_mode, 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 0);
    tick();
    rst = 1'b1;
    #1;
    check("s_ready_after_rst", s_ready, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_data.size() > 0 || in_burst) && n < 3000) begin
      tick();
      n++;
    end
    check("drained", (exp_data.size() == 0) && !in_burst, 1);
    idle(G + 4);
    check("busy_after_drain", busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    s_valid = 1'b0;
    s_sof = 1'b0;
    s_mode = 1'b0;
    s_data = '0;

    vecs[0] = '{junk: 0, partial: 0,  mode: 1'b1, base: 32'h0000_0000, exp_drop: 0};
    vecs[1] = '{junk: 5, partial: 0,  mode: 1'b0, base: 32'h0001_0000, exp_drop: 1};
    vecs[2] = '{junk: 0, partial: 20, mode: 1'b1, base: 32'h0002_0000, exp_drop: 1};
    vecs[3] = '{junk: 3, partial: 10, mode: 1'b0, base: 32'h0003_0000, exp_drop: 2};
    vecs[4] = '{junk: 0, partial: 0,  mode: 1'b0, base: 32'hffff_ffc0, exp_drop: 0};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      for (int j = 0; j < vecs[i].junk; j++) beat(32'hdead_0000 + DW'(j), 1'b0, 1'b1);
      for (int j = 0; j < vecs[i].partial; j++) beat(32'hbad0_0000 + DW'(j), j == 0, 1'b1);
      send_frame(vecs[i].base, vecs[i].mode, 1'b0);
      drain();
      check("vec_drop_cnt", drop_cnt, vecs[i].exp_drop);
      check("vec_frames", frames_out, 1);
      if (start_t.size() > 0) check("start_latency", start_t[0] - last_acc_cyc, 2);
    end

    // Continuous three-frame stream: one stall when both banks hold frames
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(32'h1000_0000 * (f + 1), f[0], 1'b0);
    drain();
    check("bp_frames", frames_out, 3);
    check("bp_stall_point", stall_at, 2 * FL);
    check("bp_bursts", start_t.size(), 3);
    if (start_t.size() >= 3) begin
      check("bp_start_spacing_1", start_t[1] - start_t[0], FL + G + 1);
      check("bp_start_spacing_2", start_t[2] - start_t[1], FL + G + 1);
    end

    // Reset in the middle of a burst, then a clean frame
    do_reset();
    send_frame(32'h5000_0000, 1'b1, 1'b0);
    begin
      int n = 0;
      while (!(in_burst && idx == 30) && n < 300) begin
        tick();
        n++;
      end
      check("reached_sample_30", in_burst && idx == 30, 1);
    end
    do_reset();
    send_frame(32'h6000_0000, 1'b0, 1'b0);
    drain();
    check("post_reset_frames", frames_out, 1);
    check("post_reset_drop", drop_cnt, 0);

    // Random 50% valid gaps, mode toggling per frame
    do_reset();
    for (int f = 0; f < 6; f++) send_frame('0, f[0], 1'b1);
    drain();
    check("rand_frames", frames_out, 6);
    check("rand_drop", drop_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
